// File: rtl/qei_velocity_sampler.sv
// Quadrature encoder position counter with tick-sampled, saturated velocity.
// Define QEI_GLITCH_FILTER_EN to add a 3-sample glitch filter on A/B.
module qei_velocity_sampler (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  input  logic        quad_a,
  input  logic        quad_b,
  input  logic        sample_tick,
  output logic        irq
);

`ifdef QEI_GLITCH_FILTER_EN
  localparam int VW = 4;
`else
  localparam int VW = 2;
`endif

  logic        wr_en, rd_en;
  logic        wr_stat, wr_ctrl, clr, rd_pos;
  logic        wd_unused;

  assign wr_en   = chipselect & ~write_n;
  assign rd_en   = chipselect & write_n;
  assign wr_stat = wr_en & (address == 3'd0);
  assign wr_ctrl = wr_en & (address == 3'd1);
  assign clr     = wr_ctrl & writedata[3];
  assign rd_pos  = rd_en & (address == 3'd2);
  assign wd_unused = ^writedata[15:4];

  logic [1:0]    sync1_q, sync2_q;
  logic [VW-1:0] vld_q;

  // Two-flop synchronizer; vld_q marks stages holding real pin samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      vld_q   <= '0;
    end else begin
      sync1_q <= {quad_a, quad_b};
      sync2_q <= sync1_q;
      vld_q   <= {vld_q[VW-2:0], 1'b1};
    end
  end

  logic [1:0] cur;
  logic       cur_vld;

`ifdef QEI_GLITCH_FILTER_EN
  logic [1:0] flt1_q, flt2_q, acc_q;
  logic       acc_vld_q;
  logic       match;

  assign match = vld_q[3] & (sync2_q == flt1_q) & (flt1_q == flt2_q);

  // Accept A/B only after three identical consecutive samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flt1_q    <= '0;
      flt2_q    <= '0;
      acc_q     <= '0;
      acc_vld_q <= 1'b0;
    end else begin
      flt1_q <= sync2_q;
      flt2_q <= flt1_q;
      if (match) begin
        acc_q     <= sync2_q;
        acc_vld_q <= 1'b1;
      end
    end
  end

  assign cur     = acc_q;
  assign cur_vld = acc_vld_q;
`else
  assign cur     = sync2_q;
  assign cur_vld = vld_q[VW-1];
`endif

  logic [1:0] prev_q;
  logic       hist_q;
  logic [1:0] cur_bin, prev_bin, step_diff;
  logic       step_up, step_dn, step_err;

  // Gray-to-binary so a forward step is always +1 modulo 4.
  assign cur_bin   = {cur[1], cur[1] ^ cur[0]};
  assign prev_bin  = {prev_q[1], prev_q[1] ^ prev_q[0]};
  assign step_diff = cur_bin - prev_bin;
  assign step_up   = hist_q & cur_vld & (step_diff == 2'd1);
  assign step_dn   = hist_q & cur_vld & (step_diff == 2'd3);
  assign step_err  = hist_q & cur_vld & (step_diff == 2'd2);

  // Decode history follows accepted input regardless of enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q <= '0;
      hist_q <= 1'b0;
    end else if (cur_vld) begin
      prev_q <= cur;
      hist_q <= 1'b1;
    end
  end

  logic [31:0] pos_q, pos_d, last_q, last_d, delta;
  logic [15:0] vel_q, vel_d, cnt_q, cnt_d, vel_sat;
  logic [15:0] shadow_q, shadow_d, rdata_q, rdata_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic        ready_q, ready_d, err_q, err_d, dir_q, dir_d;
  logic        tick_q, tick_edge;
  logic        en, irq_en, rev, inc, dec;

  assign en        = ctrl_q[0];
  assign irq_en    = ctrl_q[1];
  assign rev       = ctrl_q[2];
  assign inc       = en & (rev ? step_dn : step_up);
  assign dec       = en & (rev ? step_up : step_dn);
  assign tick_edge = sample_tick & ~tick_q;
  assign delta     = pos_q - last_q;

  // Clamp the period delta into the signed 16-bit velocity range.
  always_comb begin
    vel_sat = delta[15:0];
    if (!delta[31] && (|delta[30:15]))
      vel_sat = 16'h7fff;
    else if (delta[31] && !(&delta[30:15]))
      vel_sat = 16'h8000;
  end

  // Next-state for counters, flags, control and read mux.
  always_comb begin
    pos_d    = pos_q;
    last_d   = last_q;
    vel_d    = vel_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    ctrl_d   = ctrl_q;
    ready_d  = ready_q;
    err_d    = err_q;
    dir_d    = dir_q;
    rdata_d  = '0;

    if (inc)
      pos_d = pos_q + 32'd1;
    else if (dec)
      pos_d = pos_q - 32'd1;

    if (inc)
      dir_d = 1'b0;
    else if (dec)
      dir_d = 1'b1;

    if (tick_edge) begin
      last_d = pos_q;
      vel_d  = vel_sat;
      cnt_d  = cnt_q + 16'd1;
    end

    if (clr) begin
      pos_d  = '0;
      last_d = '0;
    end

    if (wr_stat) begin
      ready_d = 1'b0;
      err_d   = 1'b0;
    end
    if (tick_edge)
      ready_d = 1'b1;
    if (step_err)
      err_d = 1'b1;

    if (wr_ctrl)
      ctrl_d = writedata[2:0];

    if (rd_pos)
      shadow_d = pos_q[31:16];

    case (address)
      3'd0:    rdata_d = {13'b0, dir_q, err_q, ready_q};
      3'd1:    rdata_d = {13'b0, ctrl_q};
      3'd2:    rdata_d = pos_q[15:0];
      3'd3:    rdata_d = shadow_q;
      3'd4:    rdata_d = vel_q;
      3'd5:    rdata_d = cnt_q;
      default: rdata_d = '0;
    endcase
  end

  // State registers for the datapath and bus-visible registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos_q    <= '0;
      last_q   <= '0;
      vel_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      ctrl_q   <= '0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      dir_q    <= 1'b0;
      tick_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      pos_q    <= pos_d;
      last_q   <= last_d;
      vel_q    <= vel_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      ctrl_q   <= ctrl_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
      dir_q    <= dir_d;
      tick_q   <= sample_tick;
      rdata_q  <= rdata_d;
    end
  end

  assign readdata = rdata_q;
  assign irq      = irq_en & (ready_q | err_q);

endmodule

// File: tb/tb_qei_velocity_sampler.sv
// Randomized scoreboard bench for qei_velocity_sampler.
// Reads push expectations; a monitor pops them when readdata is due.
module tb_qei_velocity_sampler;

`ifdef QEI_GLITCH_FILTER_EN
  localparam int LAT    = 6;
  localparam int MINGAP = 3;
`else
  localparam int LAT    = 3;
  localparam int MINGAP = 1;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        quad_a;
  logic        quad_b;
  logic        sample_tick;
  logic        irq;

  qei_velocity_sampler dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .address     (address),
    .chipselect  (chipselect),
    .write_n     (write_n),
    .writedata   (writedata),
    .readdata    (readdata),
    .quad_a      (quad_a),
    .quad_b      (quad_b),
    .sample_tick (sample_tick),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       nm;
    logic [15:0] v;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic rd_v = 1'b0;

  always @(posedge clk) rd_v <= chipselect && write_n;

  always @(negedge clk) begin
    if (rd_v) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL stray_read got=%0h want=no read", readdata);
      end else begin
        mon_e = sb.pop_front();
        if (readdata !== mon_e.v) begin
          bad++;
          $display("FAIL %s got=%0h want=%0h", mon_e.nm, readdata, mon_e.v);
        end
      end
    end
  end

  logic [31:0] mpos, mlast;
  logic [15:0] mvel, mcnt;
  bit          mready, merr, mdir, men, mirq, mrev;
  int          ph;
  int          n;
  logic [1:0]  gray [4];
  logic [31:0] base;

  function automatic logic [15:0] sat(input logic [31:0] d);
    int s;
    s = d;
    if (s > 32767) return 16'h7fff;
    if (s < -32768) return 16'h8000;
    return s[15:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] e, input string nm);
    @(posedge clk); #1;
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    sb.push_back('{nm: nm, v: e});
  endtask

  task automatic set_ctrl(input bit en, input bit ie, input bit rv, input bit cl);
    wr(3'd1, {12'b0, cl, rv, ie, en});
    men  = en;
    mirq = ie;
    mrev = rv;
    if (cl) begin
      mpos  = '0;
      mlast = '0;
    end
  endtask

  task automatic clr_status();
    wr(3'd0, 16'hffff);
    mready = 1'b0;
    merr   = 1'b0;
  endtask

  task automatic step(input int d, input int gap);
    ph = (ph + d) & 3;
    @(posedge clk); #1;
    {quad_a, quad_b} = gray[ph];
    if (men) begin
      if ((d > 0) ^ mrev) begin
        mpos = mpos + 32'd1;
        mdir = 1'b0;
      end else begin
        mpos = mpos - 32'd1;
        mdir = 1'b1;
      end
    end
    repeat (gap - 1) @(posedge clk);
  endtask

  task automatic settle();
    repeat (LAT + 3) @(posedge clk);
  endtask

  task automatic tick();
    @(posedge clk); #1 sample_tick = 1'b1;
    @(posedge clk); #1 sample_tick = 1'b0;
    mvel   = sat(mpos - mlast);
    mlast  = mpos;
    mcnt   = mcnt + 16'd1;
    mready = 1'b1;
  endtask

  task automatic check_all(input string tag);
    rd(3'd2, mpos[15:0], {tag, "_pos_lo"});
    rd(3'd3, mpos[31:16], {tag, "_pos_hi"});
    rd(3'd4, mvel, {tag, "_vel"});
    rd(3'd5, mcnt, {tag, "_count"});
    rd(3'd0, {13'b0, mdir, merr, mready}, {tag, "_status"});
    idle();
    @(negedge clk);
    chk({tag, "_irq"}, {31'b0, irq}, {31'b0, mirq && (mready || merr)});
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    gray[0] = 2'b00;
    gray[1] = 2'b01;
    gray[2] = 2'b11;
    gray[3] = 2'b10;
    reset_n     = 1'b1;
    address     = '0;
    chipselect  = 1'b0;
    write_n     = 1'b1;
    writedata   = '0;
    quad_a      = 1'b0;
    quad_b      = 1'b0;
    sample_tick = 1'b0;
    mpos = '0; mlast = '0; mvel = '0; mcnt = '0;
    mready = 0; merr = 0; mdir = 0; men = 0; mirq = 0; mrev = 0;
    ph = 0;

    #3 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_irq", {31'b0, irq}, 32'd0);
    chk("reset_readdata", {16'b0, readdata}, 32'd0);
    reset_n = 1'b1;

    for (int a = 0; a < 8; a++)
      rd(a[2:0], 16'h0000, "reset_reg");
    idle();

    // Ten forward quadrature cycles then one sample.
    set_ctrl(1, 0, 0, 0);
    repeat (40) step(1, 8);
    settle();
    tick();
    check_all("fwd40");
    wr(3'd6, 16'hffff);
    rd(3'd6, 16'h0000, "unmapped6");
    rd(3'd7, 16'h0000, "unmapped7");
    idle();

    // Illegal two-bit jump raises quad_error and irq.
    clr_status();
    set_ctrl(1, 1, 0, 0);
    ph = (ph + 2) & 3;
    @(posedge clk); #1 {quad_a, quad_b} = gray[ph];
    merr = 1'b1;
    settle();
    check_all("jump");
    clr_status();
    @(negedge clk);
    chk("irq_cleared", {31'b0, irq}, 32'd0);

    // Random rounds against the arithmetic model.
    for (int r = 0; r < 10; r++) begin
      set_ctrl(($urandom % 4) != 0, $urandom % 2, $urandom % 2, r == 5);
      n = $urandom_range(0, 40);
      repeat (n) step((($urandom % 3) != 0) ? 1 : -1, $urandom_range(MINGAP, MINGAP + 3));
      settle();
      tick();
      check_all("rand");
      clr_status();
      @(negedge clk);
      chk("rand_irq_clr", {31'b0, irq}, 32'd0);
    end

    // Wrap below zero, then clear colliding with a step.
    set_ctrl(1, 0, 0, 1);
    step(-1, 1);
    settle();
    rd(3'd2, mpos[15:0], "wrap_lo");
    rd(3'd3, mpos[31:16], "wrap_hi");
    idle();
    chk("wrap_model", mpos, 32'hffff_ffff);
    ph = (ph + 1) & 3;
    @(posedge clk); #1 {quad_a, quad_b} = gray[ph];
    repeat (LAT - 2) @(posedge clk);
    wr(3'd1, 16'h0009);
    mpos  = '0;
    mlast = '0;
    mdir  = 1'b0;
    rd(3'd2, 16'h0000, "clr_win_lo");
    rd(3'd3, 16'h0000, "clr_win_hi");
    idle();

    // Two-cycle pulse on A: passes unfiltered, rejected when filtered.
    while (ph != 1) step(1, MINGAP + 1);
    settle();
    base = mpos;
    @(posedge clk); #1 quad_a = ~quad_a;
    @(posedge clk);
    @(posedge clk); #1 quad_a = ~quad_a;
`ifdef QEI_GLITCH_FILTER_EN
    rd(3'd2, base[15:0], "glitch_mid");
`else
    base = base + 32'd1;
    rd(3'd2, base[15:0], "glitch_mid");
    mdir = 1'b1;
`endif
    idle();
    settle();
    check_all("glitch");

    // Saturation both ways.
    set_ctrl(1, 0, 0, 0);
    tick();
    repeat (32800) step(1, MINGAP);
    settle();
    tick();
    chk("sat_pos_model", {16'b0, mvel}, 32'h7fff);
    check_all("sat_pos");
    repeat (32800) step(-1, MINGAP);
    settle();
    tick();
    chk("sat_neg_model", {16'b0, mvel}, 32'h8000);
    check_all("sat_neg");

    repeat (4) @(posedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL pending_reads got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
